// File: rtl/exmple_rr_sched.sv
// rtl/exmple_rr_sched.sv - round-robin scheduler sharing one add datapath between NREQ requesters
module exmple_rr_sched #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int LAT   = 1,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [NREQ*8-1:0] req_pdata,
  input  logic [NREQ-1:0]   req_sdata,
  output logic [NREQ-1:0]   req_rdy,
  output logic [7:0]        dp_inpdata,
  output logic              dp_insdata,
  output logic              dp_start,
  input  logic [DSIZE-1:0]  dp_ldata,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [IDW-1:0]    rsp_id,
  output logic [DSIZE-1:0]  rsp_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      ptr_q;
  logic [3:0]          cnt_q;
  logic [2*NREQ-1:0]   vld_dbl;
  logic [NREQ-1:0]     vld_rot;
  logic [IDW:0]        sum;
  logic                win_vld;
  logic [IDW-1:0]      win_idx;
  logic                accept;

  // Rotate the request vector so bit 0 is the requester at ptr; first set bit wins.
  always_comb begin
    vld_dbl = {req_vld, req_vld} >> ptr_q;
    vld_rot = vld_dbl[NREQ-1:0];
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_vld && vld_rot[k]) begin
        win_vld = 1'b1;
        sum     = {1'b0, ptr_q} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        win_idx = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    req_rdy  = '0;
    dp_start = 1'b0;
    rsp_vld  = 1'b0;
    accept   = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (win_vld && rst_n) begin
          req_rdy[win_idx] = 1'b1;
          accept           = 1'b1;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        dp_start = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
      end
      RESP: begin
        rsp_vld = 1'b1;
        if (rsp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      dp_inpdata <= '0;
      dp_insdata <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dp_inpdata <= req_pdata[8*win_idx +: 8];
        dp_insdata <= req_sdata[win_idx];
        rsp_id     <= win_idx;
        ptr_q      <= (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;
      end
      if (state_q == ISSUE) cnt_q <= 4'(LAT-1);
      // The last WAIT cycle is the one where dp_ldata is guaranteed valid.
      if (state_q == WAIT) begin
        if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        else               rsp_data <= dp_ldata;
      end
    end
  end

endmodule

// File: tb/tb_exmple_rr_sched.sv
// tb/tb_exmple_rr_sched.sv - directed self-checking bench for exmple_rr_sched
module tb_exmple_rr_sched;

  logic clock;
  logic rst_n;
  int   errors;
  int   checks;

  logic [3:0]  a_vld, a_sdata, a_req_rdy;
  logic [31:0] a_pdata;
  logic        a_rsp_rdy, a_dp_insdata, a_dp_start, a_rsp_vld, a_busy;
  logic [7:0]  a_dp_inpdata, a_dp_ldata, a_rsp_data;
  logic [1:0]  a_rsp_id;
  logic        a_dv;
  logic [7:0]  a_dq;

  logic [3:0]  b_vld, b_sdata, b_req_rdy;
  logic [31:0] b_pdata;
  logic        b_rsp_rdy, b_dp_insdata, b_dp_start, b_rsp_vld, b_busy;
  logic [7:0]  b_dp_inpdata;
  logic [8:0]  b_dp_ldata, b_rsp_data;
  logic [1:0]  b_rsp_id;
  logic [3:0]  b_v;
  logic [8:0]  b_p0, b_p1, b_p2, b_p3;

  exmple_rr_sched #(.NREQ(4), .DSIZE(8), .LAT(1)) u_a (
    .clock(clock), .rst_n(rst_n), .req_vld(a_vld), .req_pdata(a_pdata),
    .req_sdata(a_sdata), .req_rdy(a_req_rdy), .dp_inpdata(a_dp_inpdata),
    .dp_insdata(a_dp_insdata), .dp_start(a_dp_start), .dp_ldata(a_dp_ldata),
    .rsp_vld(a_rsp_vld), .rsp_rdy(a_rsp_rdy), .rsp_id(a_rsp_id),
    .rsp_data(a_rsp_data), .busy(a_busy)
  );

  exmple_rr_sched #(.NREQ(4), .DSIZE(9), .LAT(4)) u_b (
    .clock(clock), .rst_n(rst_n), .req_vld(b_vld), .req_pdata(b_pdata),
    .req_sdata(b_sdata), .req_rdy(b_req_rdy), .dp_inpdata(b_dp_inpdata),
    .dp_insdata(b_dp_insdata), .dp_start(b_dp_start), .dp_ldata(b_dp_ldata),
    .rsp_vld(b_rsp_vld), .rsp_rdy(b_rsp_rdy), .rsp_id(b_rsp_id),
    .rsp_data(b_rsp_data), .busy(b_busy)
  );

  // Datapath models: result is valid only on the exact cycle LAT after dp_start, garbage otherwise.
  always @(posedge clock) begin
    a_dv <= a_dp_start;
    if (a_dp_start) a_dq <= a_dp_inpdata + {7'b0, a_dp_insdata};
    b_v  <= {b_v[2:0], b_dp_start};
    b_p0 <= {1'b0, b_dp_inpdata} + {8'b0, b_dp_insdata};
    b_p1 <= b_p0;
    b_p2 <= b_p1;
    b_p3 <= b_p2;
  end
  assign a_dp_ldata = a_dv ? a_dq : 8'hA5;
  assign b_dp_ldata = b_v[3] ? b_p3 : 9'h0AA;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_rdy"},    32'(a_req_rdy),    32'h0);
    check({tag, "_start"},  32'(a_dp_start),   32'h0);
    check({tag, "_inp"},    32'(a_dp_inpdata), 32'h0);
    check({tag, "_ins"},    32'(a_dp_insdata), 32'h0);
    check({tag, "_rvld"},   32'(a_rsp_vld),    32'h0);
    check({tag, "_rid"},    32'(a_rsp_id),     32'h0);
    check({tag, "_rdata"},  32'(a_rsp_data),   32'h0);
    check({tag, "_busy"},   32'(a_busy),       32'h0);
  endtask

  // One LAT=1 transaction on instance a, starting in an IDLE cycle with rsp_rdy high.
  task automatic txn_a(input string tag, input int idx, input logic [7:0] pd,
                       input logic sd, input logic [7:0] exp_data);
    a_vld = 4'(1 << idx);
    a_pdata[8*idx +: 8] = pd;
    a_sdata[idx] = sd;
    #1;
    check({tag, "_rdy_T"}, 32'(a_req_rdy), 32'(1 << idx));
    cyc();
    a_vld = '0;
    #1;
    check({tag, "_start"}, 32'(a_dp_start),   32'h1);
    check({tag, "_inp"},   32'(a_dp_inpdata), 32'(pd));
    check({tag, "_ins"},   32'(a_dp_insdata), 32'(sd));
    check({tag, "_busy"},  32'(a_busy),       32'h1);
    cyc();
    #1;
    check({tag, "_wait_rvld"}, 32'(a_rsp_vld), 32'h0);
    cyc();
    #1;
    check({tag, "_rvld"},  32'(a_rsp_vld),  32'h1);
    check({tag, "_rid"},   32'(a_rsp_id),   32'(idx));
    check({tag, "_rdata"}, 32'(a_rsp_data), 32'(exp_data));
    cyc();
    #1;
    check({tag, "_idle"},  32'(a_busy),     32'h0);
  endtask

  initial begin
    logic [8:0] b_sample;
    int         lat_n;
    int         g;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    a_vld = '0; a_pdata = '0; a_sdata = '0; a_rsp_rdy = 1'b1;
    b_vld = '0; b_pdata = '0; b_sdata = '0; b_rsp_rdy = 1'b1;
    cyc(); cyc();
    check_a_reset("reset");
    check("reset_b_busy", 32'(b_busy), 32'h0);
    rst_n = 1'b1;
    cyc();

    txn_a("single", 2, 8'h10, 1'b1, 8'h11);
    txn_a("wrap8", 3, 8'hFF, 1'b1, 8'h00);

    // ptr is now 0: all four requesting must be served 0,1,2,3,0,1.
    a_vld = 4'hF;
    a_pdata = {8'h23, 8'h22, 8'h21, 8'h20};
    a_sdata = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      g = k % 4;
      #1;
      check("rr_grant", 32'(a_req_rdy), 32'(1 << g));
      cyc();
      #1;
      check("rr_issue_rdy", 32'(a_req_rdy), 32'h0);
      check("rr_inp", 32'(a_dp_inpdata), 32'(8'h20 + g));
      cyc();
      #1;
      check("rr_wait_rdy", 32'(a_req_rdy), 32'h0);
      cyc();
      #1;
      check("rr_resp_rdy", 32'(a_req_rdy), 32'h0);
      check("rr_rid", 32'(a_rsp_id), 32'(g));
      check("rr_rdata", 32'(a_rsp_data), 32'(8'h20 + g + (g % 2)));
      cyc();
    end

    // Backpressure: ptr=2, only requester 0 pending, so the search must wrap.
    a_vld = 4'b0001;
    a_pdata[7:0] = 8'h7E;
    a_sdata[0] = 1'b0;
    a_rsp_rdy = 1'b0;
    #1;
    check("bp_grant", 32'(a_req_rdy), 32'h1);
    cyc();
    a_vld = 4'hF;
    cyc();
    cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rvld",  32'(a_rsp_vld),  32'h1);
      check("bp_rid",   32'(a_rsp_id),   32'h0);
      check("bp_rdata", 32'(a_rsp_data), 32'h7E);
      check("bp_rdy",   32'(a_req_rdy),  32'h0);
      check("bp_busy",  32'(a_busy),     32'h1);
      cyc();
    end
    a_rsp_rdy = 1'b1;
    #1;
    check("bp_release_rvld", 32'(a_rsp_vld), 32'h1);
    cyc();
    #1;
    check("bp_idle_busy", 32'(a_busy), 32'h0);
    check("bp_idle_rvld", 32'(a_rsp_vld), 32'h0);
    check("bp_next_grant", 32'(a_req_rdy), 32'h2);
    a_vld = '0;

    // Reset during WAIT must abort the transaction and return ptr to 0.
    cyc();
    a_vld = 4'b0100;
    a_pdata[23:16] = 8'h55;
    #1;
    check("rst_grant", 32'(a_req_rdy), 32'h4);
    cyc();
    a_vld = '0;
    cyc();
    #1;
    check("rst_in_wait", 32'(a_busy), 32'h1);
    rst_n = 1'b0;
    a_vld = 4'b1010;
    #1;
    check_a_reset("rst_mid");
    cyc(); cyc();
    check("rst_hold_rdy", 32'(a_req_rdy), 32'h0);
    check("rst_hold_rvld", 32'(a_rsp_vld), 32'h0);
    a_vld = '0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      check("rst_after_rvld", 32'(a_rsp_vld), 32'h0);
      check("rst_after_busy", 32'(a_busy), 32'h0);
    end
    a_vld = 4'b1010;
    #1;
    check("rst_first_grant", 32'(a_req_rdy), 32'h2);
    a_vld = '0;

    // LAT=4, DSIZE=9 instance: carry into bit 8 and capture on the last WAIT cycle.
    cyc();
    b_vld = 4'b0001;
    b_pdata[7:0] = 8'hFF;
    b_sdata[0] = 1'b1;
    #1;
    check("lat4_grant", 32'(b_req_rdy), 32'h1);
    b_sample = '0;
    lat_n = 21;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      b_vld = '0;
      #1;
      if (n == 5) b_sample = b_dp_ldata;
      if (b_rsp_vld) begin
        lat_n = n;
        break;
      end
    end
    check("lat4_latency", 32'(lat_n), 32'd6);
    check("lat4_rdata", 32'(b_rsp_data), 32'h100);
    check("lat4_sampled", 32'(b_rsp_data), 32'(b_sample));
    check("lat4_rid", 32'(b_rsp_id), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
